// File: rtl/if_id_skid_reg_pkg.sv
// ============================================================================
// Module : if_id_skid_reg_pkg
// Brief  : Shared types and constants for the IF/ID skid register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package if_id_skid_reg_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [31:0]     inst;
   } if_id_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_id_skid_reg_pipe_entry_reg.sv
// ============================================================================
// Module : pipe_entry_reg
// Brief  : One pipeline entry {valid, pc, pc4, inst} with load and clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_entry_reg
   import if_id_skid_reg_pkg::*;
#(
   parameter int          N        = 32,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [N-1:0] d_pc,
   input  logic [N-1:0] d_pc4,
   input  logic [31:0]  d_inst,
   output logic         q_valid,
   output logic [N-1:0] q_pc,
   output logic [N-1:0] q_pc4,
   output logic [31:0]  q_inst
);

   // Clear only drops the valid bit; the payload holds its last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_valid <= 1'b0;
         q_pc    <= RESET_PC;
         q_pc4   <= RESET_PC;
         q_inst  <= NOP_INST;
      end else if (clear) begin
         q_valid <= 1'b0;
      end else if (load) begin
         q_valid <= 1'b1;
         q_pc    <= d_pc;
         q_pc4   <= d_pc4;
         q_inst  <= d_inst;
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_id_skid_reg.sv
// ============================================================================
// Module : if_id_skid_reg
// Brief  : IF/ID boundary register with 2-entry skid buffer and flush.
//          Optional performance counters under IFID_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_id_skid_reg
   import if_id_skid_reg_pkg::*;
#(
   parameter int          N        = 32,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_pc,
   input  logic [N-1:0] in_pc4,
   input  logic [31:0]  in_inst,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_pc,
   output logic [N-1:0] out_pc4,
   output logic [31:0]  out_inst,
`ifdef IFID_PERF_CNT_EN
   output logic [31:0]  stall_cnt,
   output logic [31:0]  flush_cnt,
`endif
   input  logic         flush
);

   logic         main_valid, skid_valid;
   logic [N-1:0] main_pc, main_pc4, skid_pc, skid_pc4;
   logic [31:0]  main_inst, skid_inst;
   logic         push, pop;
   logic         main_load, main_clear, skid_load, skid_clear;
   logic [N-1:0] main_d_pc, main_d_pc4;
   logic [31:0]  main_d_inst;

   // Ready depends only on skid occupancy, so decode stalls never reach fetch combinationally.
   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign push      = in_valid & in_ready;
   assign pop       = main_valid & out_ready;

   always_comb begin
      main_load   = 1'b0;
      main_clear  = 1'b0;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;
      main_d_pc   = in_pc;
      main_d_pc4  = in_pc4;
      main_d_inst = in_inst;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (skid_valid) begin
         // Full: fetch is blocked, so the only move is skid -> main on pop.
         if (pop) begin
            main_load   = 1'b1;
            skid_clear  = 1'b1;
            main_d_pc   = skid_pc;
            main_d_pc4  = skid_pc4;
            main_d_inst = skid_inst;
         end
      end else begin
         if (push && (!main_valid || pop))
            main_load = 1'b1;
         else if (push)
            skid_load = 1'b1;
         else if (pop)
            main_clear = 1'b1;
      end
   end

   pipe_entry_reg #(.N(N), .RESET_PC(RESET_PC)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (main_load),
      .clear   (main_clear),
      .d_pc    (main_d_pc),
      .d_pc4   (main_d_pc4),
      .d_inst  (main_d_inst),
      .q_valid (main_valid),
      .q_pc    (main_pc),
      .q_pc4   (main_pc4),
      .q_inst  (main_inst)
   );

   pipe_entry_reg #(.N(N), .RESET_PC(RESET_PC)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clear   (skid_clear),
      .d_pc    (in_pc),
      .d_pc4   (in_pc4),
      .d_inst  (in_inst),
      .q_valid (skid_valid),
      .q_pc    (skid_pc),
      .q_pc4   (skid_pc4),
      .q_inst  (skid_inst)
   );

   assign out_pc   = main_pc;
   assign out_pc4  = main_pc4;
   assign out_inst = main_valid ? main_inst : NOP_INST;

`ifdef IFID_PERF_CNT_EN
   // A main entry popped in the flush cycle was consumed, not discarded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (main_valid && !out_ready)
            stall_cnt <= stall_cnt + 32'd1;
         if (flush)
            flush_cnt <= flush_cnt + 32'(skid_valid) + 32'(main_valid & ~out_ready);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
// ============================================================================
// Module : tb_if_id_skid_reg
// Brief  : Directed self-checking bench for if_id_skid_reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_skid_reg;

   localparam logic [31:0] RST_PC = 32'h0000_1000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0, in_pc4 = '0, in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_pc4, out_inst;
   logic        flush = 1'b0;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   if_id_skid_reg #(.N(32), .RESET_PC(RST_PC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_pc4    (in_pc4),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_pc4   (out_pc4),
      .out_inst  (out_inst),
`ifdef IFID_PERF_CNT_EN
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt),
`endif
      .flush     (flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_pc4   = pc + 32'd4;
      in_inst  = 32'hA000_0000 | pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_pc", out_pc, RST_PC);
      check("rst_pc4", out_pc4, RST_PC);
      check("rst_inst", out_inst, NOP);
      rst = 1'b1;
      tick();

      // Streaming
      out_ready = 1'b1;
      drive(1'b1, 32'h0); tick();
      check("s0_valid", {31'd0, out_valid}, 32'd1);
      check("s0_pc", out_pc, 32'h0);
      check("s0_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h4); tick();
      check("s1_pc", out_pc, 32'h4);
      check("s1_pc4", out_pc4, 32'h8);
      drive(1'b1, 32'h8); tick();
      check("s2_pc", out_pc, 32'h8);
      check("s2_inst", out_inst, 32'hA000_0008);
      check("s2_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 32'h0); tick();
      check("s_drain_valid", {31'd0, out_valid}, 32'd0);
      check("s_drain_inst", out_inst, NOP);

      // Stall and skid
      out_ready = 1'b0;
      drive(1'b1, 32'h10); tick();
      check("st0_pc", out_pc, 32'h10);
      check("st0_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h14); tick();
      check("st1_pc", out_pc, 32'h10);
      check("st1_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 32'h18); tick();
      check("st2_pc", out_pc, 32'h10);
      check("st2_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1; tick();
      check("st3_pc", out_pc, 32'h14);
      check("st3_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("st4_pc", out_pc, 32'h18);
      check("st4_valid", {31'd0, out_valid}, 32'd1);
      drive(1'b0, 32'h0); tick();
      check("st5_valid", {31'd0, out_valid}, 32'd0);

      // Flush while two entries held
      out_ready = 1'b0;
      drive(1'b1, 32'h40); tick();
      drive(1'b1, 32'h44); tick();
      check("f_full", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 32'h20); flush = 1'b1; tick();
      flush = 1'b0;
      check("f_valid", {31'd0, out_valid}, 32'd0);
      check("f_ready", {31'd0, in_ready}, 32'd1);
      check("f_inst", out_inst, NOP);
      check("f_pc_hold", out_pc, 32'h40);
`ifdef IFID_PERF_CNT_EN
      check("f_cnt", flush_cnt, 32'd2);
`endif
      drive(1'b0, 32'h0); tick();
      check("f_after", {31'd0, out_valid}, 32'd0);

      // Flush drops a push accepted in the same cycle
      drive(1'b1, 32'h50); tick();
      drive(1'b1, 32'h54); flush = 1'b1; tick();
      flush = 1'b0; drive(1'b0, 32'h0);
      check("fp_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("fp_after", {31'd0, out_valid}, 32'd0);

      // Flush together with pop
      drive(1'b1, 32'h30); tick();
      drive(1'b1, 32'h34); out_ready = 1'b1; flush = 1'b1;
      #1;
      check("fq_pop_pc", out_pc, 32'h30);
      check("fq_pop_valid", {31'd0, out_valid}, 32'd1);
      tick();
      flush = 1'b0; drive(1'b0, 32'h0);
      check("fq_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("fq_after", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset mid-operation
      out_ready = 1'b0;
      drive(1'b1, 32'h70); tick();
      drive(1'b1, 32'h74); tick();
      drive(1'b0, 32'h0);
      #2; rst = 1'b0; #1;
      check("ar_valid", {31'd0, out_valid}, 32'd0);
      check("ar_ready", {31'd0, in_ready}, 32'd1);
      check("ar_inst", out_inst, NOP);
      check("ar_pc", out_pc, RST_PC);
      #2; rst = 1'b1;
      tick();
      check("ar_after", {31'd0, out_valid}, 32'd0);

      // Stall counting
      drive(1'b1, 32'h60); tick();
      drive(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) tick();
      check("sc_pc", out_pc, 32'h60);
`ifdef IFID_PERF_CNT_EN
      check("sc_cnt", stall_cnt, 32'd5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
